rx_frame_router: RTL and testbench
==================================

// Module: rx_frame_router
// PURPOSE
//  Parametrised successor to the fixed three-target rx bus parser. Once rx_done is seen, it
//  reads one received frame out of the rx buffer through a single owned read port. It checks
//  the CRC verdict and the station address, decodes the header, then streams the payload
//  into one of NUM_CH destination buffers. Sits between the bus MAC rx buffer and the
//  LDDB/LCDCB/LCDDB-style data banks.
// PARAMETERS
//  BUF_AW      11   rx buffer address width (bytes)
//  ADDR_BYTES  3    header address field length, bytes (1..4); DST_AW = 8*ADDR_BYTES
//  NUM_CH      3    number of destination channels (1..8)
//  MAX_LEN     1024 max payload bytes accepted; longer -> drop
//  BCAST_DA    8'hFF broadcast destination address
// PORTS
//  clk          in   1            system clock
//  reset        in   1            async reset, active-high
//  rx_done      in   1            pulse: frame complete in rx buffer
//  rx_crc_rslt  in   2            00 pending, 01 ok, 10 bad, 11 treated as bad
//  ini_done     in   1            frames are ignored while 0
//  rack_id      in   3            station rack number
//  slot_id      in   4            station slot number
//  rx_buf_rden  out  1            rx buffer read enable
//  rx_buf_raddr out  BUF_AW       rx buffer byte address
//  rx_buf_rdata in   8            read data, valid 1 clk after rden
//  ch_wren      out  NUM_CH       one-hot destination write enable
//  ch_waddr     out  DST_AW       destination byte address (shared)
//  ch_wdata     out  8            destination write data (shared)
//  rx_mode      out  8            MODE byte of last accepted frame
//  rx_addr      out  DST_AW       ADDR field of last accepted frame
//  rx_flag      out  1            1-clk pulse: frame fully written
//  crc_err      out  1            1-clk pulse: CRC bad
//  drop_cnt     out  16           saturating count of dropped frames (any cause)
//  busy         out  1            high whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; all counters 0.
//  Frame layout (byte offsets): 0 DA, 1 FC, 2 MODE, 3..2+ADDR_BYTES ADDR (MSB first),
//   then LEN_HI, LEN_LO, then LEN payload bytes.
//  FSM states, in order:
//   IDLE -> WAIT_CRC on rx_done & ini_done. rx_done in any other state is ignored and
//     counted as a drop.
//   WAIT_CRC: hold until rx_crc_rslt != 00. Then 01 -> HDR; else pulse crc_err -> DROP.
//     Timeout: 64 clk with no verdict -> DROP.
//   HDR: read offsets 0..4+ADDR_BYTES back-to-back, one address per clk; rdata is
//     captured 1 clk later. Checks, then action:
//     - DA must equal {1'b0,rack_id,slot_id} or BCAST_DA;
//     - FC[2:0] must be < NUM_CH;
//     - 0 < LEN <= MAX_LEN.
//     Any failure -> DROP. Otherwise latch rx_mode and rx_addr -> PAY.
//   PAY: read payload bytes in ascending order. For payload byte k:
//     - ch_wren[FC] is high on the clk its data is valid; ch_wdata = byte;
//     - ch_waddr = ADDR + k, wrapping modulo 2^DST_AW.
//     1 byte per clk, no gaps; pipeline latency rden -> wren is 1 clk.
//     If rx_buf_raddr reaches 2^BUF_AW-1 before LEN is exhausted -> DROP, keeping any
//     writes already issued.
//   DONE: 1 clk; pulse rx_flag -> IDLE.
//   DROP: 1 clk; drop_cnt++ (saturates at FFFF) -> IDLE.
//  Only one of ch_wren is ever high at a time. rden is deasserted in IDLE, WAIT_CRC,
//   DONE and DROP.
//  Reset asserted mid-frame aborts immediately: writes stop, no flag pulses.
//  rx_done arriving in the same clk as DONE is dropped; rx_done is accepted again from
//   IDLE only.
// STRUCTURE
//  Shared package rx_bus_pkg: FSM state enum, CRC_OK/CRC_BAD codes, header offset
//   constants, CRC_TIMEOUT=64.
//  One sub-module, rx_hdr_capture: shifts header bytes in and outputs DA/FC/MODE/ADDR/LEN
//   plus hdr_valid. Everything else (read-address counter, payload counter, channel
//   demux) lives in the top.
// TESTING
//  1 rack=1, slot=2. Frame DA=8'h12, FC=1, MODE=8'h5A, ADDR=24'h000100, LEN=4, payload
//    AA BB CC DD, crc=01 -> ch_wren=3'b010 with waddr 100..103 and data AA..DD on
//    consecutive clks; rx_flag 1 clk; rx_mode=5A.
//  2 Same frame with DA=FF -> accepted, as in test 1. DA=13 -> no wren, drop_cnt=1, no
//    rx_flag.
//  3 crc=10 -> crc_err 1 clk, drop_cnt+1, no buffer reads past WAIT_CRC. Crc held at 00
//    -> DROP after 64 clk.
//  4 FC=3 with NUM_CH=3 -> drop. LEN=0 and LEN=1025 -> drop. ADDR=24'hFFFFFE, LEN=4 ->
//    waddr FFFFFE, FFFFFF, 000000, 000001.
//  5 Second rx_done during PAY -> current frame completes normally and drop_cnt+1.
//    Reset asserted during PAY byte 2 -> wren 0 next clk, all outputs 0.
//  6 ini_done=0 with rx_done -> state remains IDLE, no reads issued.

Source files
------------

// File: rtl/rx_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rx_bus_pkg
//  Purpose  : Shared types and constants for the rx frame router.
//  Revision : 1.0  initial release
// ============================================================================
package rx_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CRC = 3'd1,
        ST_HDR      = 3'd2,
        ST_PAY      = 3'd3,
        ST_DONE     = 3'd4,
        ST_DROP     = 3'd5
    } rx_state_t;

    localparam logic [1:0] CRC_PENDING = 2'b00;
    localparam logic [1:0] CRC_OK      = 2'b01;
    localparam logic [1:0] CRC_BAD     = 2'b10;

    // Header byte offsets; LEN follows the ADDR field
    localparam int OFS_DA      = 0;
    localparam int OFS_FC      = 1;
    localparam int OFS_MODE    = 2;
    localparam int OFS_ADDR    = 3;
    localparam int LEN_BYTES   = 2;

    localparam int CRC_TIMEOUT = 64;

    // Total header length in bytes for a given ADDR field length
    function automatic int hdr_len(input int addr_bytes);
        return OFS_ADDR + addr_bytes + LEN_BYTES;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_hdr_capture.sv
`default_nettype none
// ============================================================================
//  Module   : rx_hdr_capture
//  Purpose  : Shifts the frame header in byte by byte and presents the decoded
//             DA / FC / MODE / ADDR / LEN fields once all bytes have arrived.
//  Revision : 1.0  initial release
// ============================================================================
module rx_hdr_capture
    import rx_bus_pkg::*;
#(
    parameter int ADDR_BYTES = 3,
    localparam int DST_AW    = 8 * ADDR_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_byte_vld,
    input  logic [7:0]        i_byte_data,
    output logic [7:0]        o_da,
    output logic [7:0]        o_fc,
    output logic [7:0]        o_mode,
    output logic [DST_AW-1:0] o_addr,
    output logic [15:0]       o_len,
    output logic              o_hdr_valid
);

    localparam int c_hdr_len  = hdr_len(ADDR_BYTES);
    localparam int c_hdr_bits = 8 * c_hdr_len;
    localparam int c_cnt_w    = $clog2(c_hdr_len + 1);

    logic [c_hdr_bits-1:0] r_shift;
    logic [c_cnt_w-1:0]    r_cnt;

    // Shift bytes in MSB-first until the full header has been collected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_byte_vld && (r_cnt != c_cnt_w'(c_hdr_len))) begin
            r_shift <= {r_shift[c_hdr_bits-9:0], i_byte_data};
            r_cnt   <= r_cnt + c_cnt_w'(1);
        end
    end

    // Byte 0 ends up in the top byte once the header is complete
    assign o_da        = r_shift[c_hdr_bits-1-8*OFS_DA   -: 8];
    assign o_fc        = r_shift[c_hdr_bits-1-8*OFS_FC   -: 8];
    assign o_mode      = r_shift[c_hdr_bits-1-8*OFS_MODE -: 8];
    assign o_addr      = r_shift[c_hdr_bits-1-8*OFS_ADDR -: DST_AW];
    assign o_len       = r_shift[15:0];
    assign o_hdr_valid = (r_cnt == c_cnt_w'(c_hdr_len));

endmodule
`default_nettype wire

// File: rtl/rx_frame_router.sv
`default_nettype none
// ============================================================================
//  Module   : rx_frame_router
//  Purpose  : Reads one received frame out of the rx buffer, validates CRC
//             verdict, station address and header, then streams the payload
//             into one of NUM_CH destination buffers.
//  Revision : 1.0  initial release
// ============================================================================
module rx_frame_router
    import rx_bus_pkg::*;
#(
    parameter int         BUF_AW     = 11,
    parameter int         ADDR_BYTES = 3,
    parameter int         NUM_CH     = 3,
    parameter int         MAX_LEN    = 1024,
    parameter logic [7:0] BCAST_DA   = 8'hFF,
    localparam int        DST_AW     = 8 * ADDR_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [1:0]        rx_crc_rslt,
    input  logic              ini_done,
    input  logic [2:0]        rack_id,
    input  logic [3:0]        slot_id,
    output logic              rx_buf_rden,
    output logic [BUF_AW-1:0] rx_buf_raddr,
    input  logic [7:0]        rx_buf_rdata,
    output logic [NUM_CH-1:0] ch_wren,
    output logic [DST_AW-1:0] ch_waddr,
    output logic [7:0]        ch_wdata,
    output logic [7:0]        rx_mode,
    output logic [DST_AW-1:0] rx_addr,
    output logic              rx_flag,
    output logic              crc_err,
    output logic [15:0]       drop_cnt,
    output logic              busy
);

    localparam int c_hdr_len = hdr_len(ADDR_BYTES);
    localparam int c_tmo_w   = $clog2(CRC_TIMEOUT);

    rx_state_t         r_state, w_state_nxt;
    logic [BUF_AW-1:0] r_raddr;
    logic [15:0]       r_left;
    logic [c_tmo_w-1:0] r_tmo;
    logic              r_hdr_vld, r_pay_vld, r_crc_err;
    logic [2:0]        r_ch;
    logic [DST_AW-1:0] r_waddr, r_rx_addr;
    logic [7:0]        r_rx_mode;
    logic [15:0]       r_drop_cnt;

    logic              w_rden, w_start, w_crc_bad, w_hdr_ok, w_accept;
    logic [7:0]        w_da, w_fc, w_mode;
    logic [DST_AW-1:0] w_addr;
    logic [15:0]       w_len;
    logic              w_hdr_valid;
    logic [1:0]        w_drop_inc;
    logic [16:0]       w_drop_sum;
    logic              w_unused_fc;

    assign w_start   = (r_state == ST_IDLE) && rx_done && ini_done;
    assign w_crc_bad = ((rx_crc_rslt & CRC_BAD) != 2'b00);
    assign w_hdr_ok  = ((w_da == {1'b0, rack_id, slot_id}) || (w_da == BCAST_DA)) &&
                       ({1'b0, w_fc[2:0]} < 4'(NUM_CH)) &&
                       (w_len != 16'd0) && (w_len <= 16'(MAX_LEN));
    assign w_accept  = (r_state == ST_HDR) && w_hdr_valid && w_hdr_ok;
    // Only the low three FC bits select a channel
    assign w_unused_fc = &{1'b0, w_fc[7:3]};

    rx_hdr_capture #(
        .ADDR_BYTES (ADDR_BYTES)
    ) u_hdr (
        .clk         (clk),
        .rst         (reset),
        .i_clear     (w_start),
        .i_byte_vld  (r_hdr_vld),
        .i_byte_data (rx_buf_rdata),
        .o_da        (w_da),
        .o_fc        (w_fc),
        .o_mode      (w_mode),
        .o_addr      (w_addr),
        .o_len       (w_len),
        .o_hdr_valid (w_hdr_valid)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and buffer read-enable decode
    always_comb begin
        w_state_nxt = r_state;
        w_rden      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_WAIT_CRC;
            end
            ST_WAIT_CRC: begin
                if (rx_crc_rslt == CRC_OK)                         w_state_nxt = ST_HDR;
                else if (rx_crc_rslt != CRC_PENDING)               w_state_nxt = ST_DROP;
                else if (r_tmo == c_tmo_w'(CRC_TIMEOUT - 1))       w_state_nxt = ST_DROP;
            end
            ST_HDR: begin
                w_rden = (r_raddr < BUF_AW'(c_hdr_len));
                if (w_hdr_valid) w_state_nxt = w_hdr_ok ? ST_PAY : ST_DROP;
            end
            ST_PAY: begin
                // The last byte is being written when the remaining count hits zero
                if (r_left == 16'd0)        w_state_nxt = ST_DONE;
                else if (r_raddr == '1)     w_state_nxt = ST_DROP;
                else                        w_rden      = 1'b1;
            end
            ST_DONE, ST_DROP: w_state_nxt = ST_IDLE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    // Read address, CRC timeout and read-data pipeline tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_raddr   <= '0;
            r_tmo     <= '0;
            r_hdr_vld <= 1'b0;
            r_pay_vld <= 1'b0;
            r_crc_err <= 1'b0;
        end else begin
            r_hdr_vld <= w_rden && (r_state == ST_HDR);
            r_pay_vld <= w_rden && (r_state == ST_PAY);
            r_crc_err <= (r_state == ST_WAIT_CRC) && w_crc_bad;
            if (w_start) begin
                r_raddr <= '0;
                r_tmo   <= '0;
            end else begin
                if (w_rden) r_raddr <= r_raddr + BUF_AW'(1);
                if (r_state == ST_WAIT_CRC) r_tmo <= r_tmo + c_tmo_w'(1);
            end
        end
    end

    // Header latch on accept, then payload count and destination address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left    <= '0;
            r_ch      <= '0;
            r_waddr   <= '0;
            r_rx_addr <= '0;
            r_rx_mode <= '0;
        end else if (w_accept) begin
            r_left    <= w_len;
            r_ch      <= w_fc[2:0];
            r_waddr   <= w_addr;
            r_rx_addr <= w_addr;
            r_rx_mode <= w_mode;
        end else begin
            if (w_rden && (r_state == ST_PAY)) r_left <= r_left - 16'd1;
            if (r_pay_vld) r_waddr <= r_waddr + DST_AW'(1);
        end
    end

    // A DROP and an ignored rx_done can coincide, so the step can be two
    assign w_drop_inc = {1'b0, (r_state == ST_DROP)} +
                        {1'b0, (rx_done && (r_state != ST_IDLE))};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};

    // Saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_drop_cnt <= '0;
        else       r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_wren
            assign ch_wren[i] = r_pay_vld && (r_ch == 3'(i));
        end
    endgenerate

    assign rx_buf_rden  = w_rden;
    assign rx_buf_raddr = r_raddr;
    assign ch_waddr     = r_waddr;
    assign ch_wdata     = r_pay_vld ? rx_buf_rdata : 8'h00;
    assign rx_mode      = r_rx_mode;
    assign rx_addr      = r_rx_addr;
    assign rx_flag      = (r_state == ST_DONE);
    assign crc_err      = r_crc_err;
    assign drop_cnt     = r_drop_cnt;
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_frame_router
//  Purpose  : Self-checking bench for rx_frame_router with a frame-level
//             reference model and a simple rx buffer responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rx_frame_router;

    localparam int         BUF_AW  = 11;
    localparam int         NUM_CH  = 3;
    localparam int         DST_AW  = 24;
    localparam int         MAX_LEN = 1024;
    localparam int         HDR_B   = 8;
    localparam logic [2:0] RACK    = 3'd1;
    localparam logic [3:0] SLOT    = 4'd2;

    logic              clk = 1'b0;
    logic              reset, rx_done, ini_done;
    logic [1:0]        rx_crc_rslt;
    logic [2:0]        rack_id;
    logic [3:0]        slot_id;
    logic              rx_buf_rden;
    logic [BUF_AW-1:0] rx_buf_raddr;
    logic [7:0]        rx_buf_rdata;
    logic [NUM_CH-1:0] ch_wren;
    logic [DST_AW-1:0] ch_waddr, rx_addr;
    logic [7:0]        ch_wdata, rx_mode;
    logic              rx_flag, crc_err, busy;
    logic [15:0]       drop_cnt;

    always #5 clk = ~clk;

    rx_frame_router dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done      (rx_done),
        .rx_crc_rslt  (rx_crc_rslt),
        .ini_done     (ini_done),
        .rack_id      (rack_id),
        .slot_id      (slot_id),
        .rx_buf_rden  (rx_buf_rden),
        .rx_buf_raddr (rx_buf_raddr),
        .rx_buf_rdata (rx_buf_rdata),
        .ch_wren      (ch_wren),
        .ch_waddr     (ch_waddr),
        .ch_wdata     (ch_wdata),
        .rx_mode      (rx_mode),
        .rx_addr      (rx_addr),
        .rx_flag      (rx_flag),
        .crc_err      (crc_err),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    // rx buffer: data returned one clock after the read enable
    logic [7:0] mem [0:(1<<BUF_AW)-1];
    always @(posedge clk) if (rx_buf_rden) rx_buf_rdata <= mem[rx_buf_raddr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          ch;
        logic [23:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t wq[$];
    wr_t mon_w;
    int  cyc = 0;
    int  n_rd, n_flag, n_crcerr, n_busy;

    // Observe the DUT on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (rx_buf_rden) n_rd++;
        if (rx_flag)     n_flag++;
        if (crc_err)     n_crcerr++;
        if (busy)        n_busy++;
        if (ch_wren != '0) begin
            check("wren_onehot", 64'($countones(ch_wren)), 64'd1);
            mon_w.ch = -1;
            for (int i = 0; i < NUM_CH; i++) if (ch_wren[i]) mon_w.ch = i;
            mon_w.addr = ch_waddr;
            mon_w.data = ch_wdata;
            mon_w.cyc  = cyc;
            wq.push_back(mon_w);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int          exp_drop = 0;
    logic [7:0]  exp_mode = 8'h00;
    logic [23:0] exp_addr = 24'h0;

    // One frame end to end; crc_dly < 0 never delivers a verdict,
    // extra_at > 0 pulses a second rx_done at that cycle of the frame
    task automatic run_frame(input logic [7:0] da, input logic [7:0] fc, input logic [7:0] mode,
                             input logic [23:0] addr, input int len, input logic [1:0] crc,
                             input int crc_dly, input int extra_at, input bit fixed_pay);
        logic [7:0] pay[$];
        bit         crc_ok, crc_bad, hdr_good, acc;
        int         exp_rd, c, nw;
        logic [15:0] l16;
        l16 = 16'(len);
        mem[0] = da; mem[1] = fc; mem[2] = mode;
        mem[3] = addr[23:16]; mem[4] = addr[15:8]; mem[5] = addr[7:0];
        mem[6] = l16[15:8]; mem[7] = l16[7:0];
        for (int k = 0; k < len; k++) begin
            pay.push_back(fixed_pay ? 8'(8'hAA + 8'h11 * k) : 8'($urandom));
            mem[HDR_B + k] = pay[k];
        end

        crc_ok   = (crc_dly >= 0) && (crc == 2'b01);
        crc_bad  = (crc_dly >= 0) && (crc[1] == 1'b1);
        hdr_good = ((da == {1'b0, RACK, SLOT}) || (da == 8'hFF)) &&
                   (int'(fc[2:0]) < NUM_CH) && (len > 0) && (len <= MAX_LEN);
        acc      = crc_ok && hdr_good;
        exp_rd   = crc_ok ? (hdr_good ? HDR_B + len : HDR_B) : 0;
        exp_drop += (acc ? 0 : 1) + ((extra_at > 0) ? 1 : 0);
        if (acc) begin
            exp_mode = mode;
            exp_addr = addr;
        end

        wq.delete();
        n_rd = 0; n_flag = 0; n_crcerr = 0; n_busy = 0;
        rx_crc_rslt = 2'b00;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        c = 1;
        while (1) begin
            if (c == crc_dly) rx_crc_rslt = crc;
            rx_done = (c == extra_at);
            tick();
            c++;
            if (!busy && c > 2) break;
            if (c > 3000) begin
                check("frame_end_timeout", 64'(busy), 64'd0);
                break;
            end
        end
        rx_done = 1'b0;
        rx_crc_rslt = 2'b00;

        check("buf_reads", 64'(n_rd), 64'(exp_rd));
        check("rx_flag_pulses", 64'(n_flag), 64'(acc));
        check("crc_err_pulses", 64'(n_crcerr), 64'(crc_bad));
        check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        check("rx_mode", 64'(rx_mode), 64'(exp_mode));
        check("rx_addr", 64'(rx_addr), 64'(exp_addr));
        check("write_count", 64'(wq.size()), 64'(acc ? len : 0));
        nw = (wq.size() < pay.size()) ? wq.size() : pay.size();
        if (!acc) nw = 0;
        for (int k = 0; k < nw; k++) begin
            check("wr_ch", 64'(wq[k].ch), 64'(fc[2:0]));
            check("wr_addr", 64'(wq[k].addr), 64'(24'(addr + 24'(k))));
            check("wr_data", 64'(wq[k].data), 64'(pay[k]));
        end
        if (wq.size() > 0)
            check("wr_no_gaps", 64'(wq[wq.size()-1].cyc - wq[0].cyc), 64'(wq.size() - 1));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  r_da, r_fc;
        logic [23:0] r_addr;
        logic [1:0]  r_crc;
        int          sel, r_len, c;

        reset = 1'b1; rx_done = 1'b0; ini_done = 1'b1; rx_crc_rslt = 2'b00;
        rack_id = RACK; slot_id = SLOT;
        repeat (3) tick();
        check("reset_out_a", 64'({rx_buf_rden, rx_buf_raddr, ch_wren, ch_waddr, ch_wdata,
                                  rx_flag, crc_err, busy}), 64'd0);
        check("reset_out_b", 64'({rx_mode, rx_addr, drop_cnt}), 64'd0);
        reset = 1'b0;
        tick();

        // Own address, channel 1, fixed payload AA..DD
        run_frame(8'h12, 8'h01, 8'h5A, 24'h000100, 4, 2'b01, 2, 0, 1'b1);
        // Broadcast accepted, foreign address dropped
        run_frame(8'hFF, 8'h01, 8'h5A, 24'h000100, 4, 2'b01, 1, 0, 1'b1);
        run_frame(8'h13, 8'h01, 8'h66, 24'h000200, 4, 2'b01, 1, 0, 1'b0);
        // Bad CRC codes and verdict timeout
        run_frame(8'h12, 8'h00, 8'h11, 24'h000300, 4, 2'b10, 3, 0, 1'b0);
        run_frame(8'h12, 8'h00, 8'h11, 24'h000300, 4, 2'b11, 1, 0, 1'b0);
        run_frame(8'h12, 8'h00, 8'h11, 24'h000300, 4, 2'b01, -1, 0, 1'b0);
        check("crc_timeout_busy_cycles", 64'(n_busy), 64'(65));
        // Header boundaries
        run_frame(8'h12, 8'h03, 8'h21, 24'h000010, 4, 2'b01, 1, 0, 1'b0);
        run_frame(8'h12, 8'h02, 8'h22, 24'h000010, 0, 2'b01, 1, 0, 1'b0);
        run_frame(8'h12, 8'h02, 8'h23, 24'h000010, 1025, 2'b01, 1, 0, 1'b0);
        run_frame(8'h12, 8'h02, 8'h24, 24'h000040, 1, 2'b01, 1, 0, 1'b0);
        run_frame(8'h12, 8'h00, 8'h25, 24'hFFFFFE, 4, 2'b01, 2, 0, 1'b0);
        run_frame(8'h12, 8'hF9, 8'h26, 24'h001000, 1024, 2'b01, 1, 0, 1'b0);
        // Second rx_done while payload streams
        run_frame(8'h12, 8'h02, 8'h27, 24'h000500, 20, 2'b01, 2, 20, 1'b0);

        // Frames ignored before initialisation completes
        ini_done = 1'b0;
        n_rd = 0; n_busy = 0;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        repeat (10) tick();
        check("ini0_busy", 64'(n_busy), 64'd0);
        check("ini0_reads", 64'(n_rd), 64'd0);
        check("ini0_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        ini_done = 1'b1;
        tick();

        // Randomised frames
        for (int i = 0; i < 40; i++) begin
            sel    = $urandom_range(0, 3);
            r_da   = (sel == 0) ? 8'h12 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'h13 : 8'($urandom);
            r_fc   = {5'($urandom), (($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)))};
            sel    = $urandom_range(0, 9);
            r_len  = (sel == 0) ? 0 : (sel == 1) ? 1025 : int'($urandom_range(1, 24));
            r_addr = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'(24'hFFFFF0 + 24'($urandom_range(0, 15)));
            sel    = $urandom_range(0, 7);
            r_crc  = (sel == 0) ? 2'b10 : (sel == 1) ? 2'b11 : 2'b01;
            run_frame(r_da, r_fc, 8'($urandom), r_addr, r_len, r_crc, int'($urandom_range(1, 6)), 0, 1'b0);
        end

        // Reset in the middle of the payload
        mem[0] = 8'h12; mem[1] = 8'h01; mem[2] = 8'h77;
        mem[3] = 8'h00; mem[4] = 8'h08; mem[5] = 8'h00;
        mem[6] = 8'h00; mem[7] = 8'd16;
        for (int k = 0; k < 16; k++) mem[HDR_B + k] = 8'(k);
        wq.delete();
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_crc_rslt = 2'b01;
        c = 0;
        while (wq.size() < 2 && c < 200) begin
            tick();
            c++;
        end
        check("rst_mid_reached_pay", 64'(wq.size()), 64'd2);
        reset = 1'b1;
        #1;
        check("rst_mid_out_a", 64'({rx_buf_rden, rx_buf_raddr, ch_wren, ch_waddr, ch_wdata,
                                    rx_flag, crc_err, busy}), 64'd0);
        check("rst_mid_out_b", 64'({rx_mode, rx_addr, drop_cnt}), 64'd0);
        n_flag = 0;
        tick();
        check("rst_mid_wren", 64'(ch_wren), 64'd0);
        check("rst_mid_no_flag", 64'(n_flag), 64'd0);
        exp_drop = 0; exp_mode = 8'h00; exp_addr = 24'h0;
        rx_crc_rslt = 2'b00;
        reset = 1'b0;
        tick();
        // Normal operation resumes after reset
        run_frame(8'h12, 8'h01, 8'h5A, 24'h000100, 4, 2'b01, 2, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
